// File: rtl/mem1_data_responder.sv
// rtl/mem1_data_responder.sv - Memory1 data-access responder with multi-cycle local data RAM
//
// Purpose: accepts one load/store from the Memory1 stage, stalls the pipeline
// for LATENCY+1 cycles, then pulses resp_valid with sign/zero-extended load data.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_valid       Memory1 holds a valid instruction
//   clear           Memory1 squash flag
//   v_addr          byte address
//   memory_rw       01 read, 10 write, 00/11 no access
//   number_length   [1:0] size (00 byte, 01 half, 1x word), [2] zero-extend load
//   wdata           store data (low bytes used for byte/half)
//   stall           hold Memory1 register
//   resp_valid      one-cycle completion pulse
//   rdata           extended load data (0 on writes)
//   ale             misaligned-access flag, valid with resp_valid
//
// Optional feature macro: MEM1_ALIGN_CHECK_EN
//   defined   - misaligned half/word accesses flag ale, suppress the store, return 0
//   undefined - ale tied 0, low address bits beyond the access size are ignored

module mem1_data_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        clear,
    input  logic [31:0] v_addr,
    input  logic [1:0]  memory_rw,
    input  logic [2:0]  number_length,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        ale
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t state, state_nxt;

    logic [CW-1:0]   cnt;
    logic [AW+1:0]   addr_q;
    logic            wr_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic [31:0]     wdata_q;
    logic            drop_q;

    logic [31:0]     mem [DEPTH];

    logic            req_present;
    logic            do_access;
    logic            mis;
    logic [AW-1:0]   idx;
    logic [1:0]      off;
    logic [31:0]     word;
    logic [15:0]     lane;
    logic [31:0]     ext;
    logic [3:0]      be;
    logic [31:0]     wrep;

    // Address bits above the RAM index are deliberately dropped (aliasing).
    logic            unused_addr_bits;
    assign unused_addr_bits = ^v_addr[31:AW+2];

    assign req_present = req_valid & ~clear & (memory_rw == 2'b01 | memory_rw == 2'b10);
    assign do_access   = (state == BUSY) && (cnt == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; RESP always returns to IDLE so a held request is not re-accepted
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_present) state_nxt = BUSY;
            BUSY:    if (cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: stall is combinational so the accepting cycle already holds Memory1
    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = req_present;
            BUSY:    stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    // Access decode on the latched request
`ifdef MEM1_ALIGN_CHECK_EN
    assign mis = ((size_q == 2'b01) && addr_q[0]) || (size_q[1] && (addr_q[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif

    always_comb begin
        idx  = addr_q[AW+1:2];
        word = mem[idx];
        off  = 2'b00;
        be   = 4'b1111;
        wrep = wdata_q;
        case (size_q)
            2'b00: begin
                off  = addr_q[1:0];
                be   = 4'b0001 << off;
                wrep = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                off  = {addr_q[1], 1'b0};
                be   = addr_q[1] ? 4'b1100 : 4'b0011;
                wrep = {2{wdata_q[15:0]}};
            end
            default: begin
                off  = 2'b00;
                be   = 4'b1111;
                wrep = wdata_q;
            end
        endcase
        lane = 16'(word >> {off, 3'b000});
        case (size_q)
            2'b00:   ext = uns_q ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            2'b01:   ext = uns_q ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: ext = word;
        endcase
    end

    // RAM write port; a store still pending when rst arrives is abandoned
    always_ff @(posedge clk) begin
        if (do_access && wr_q && !mis && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wrep[8*b +: 8];
                end
            end
        end
    end

    // Request capture, latency counter and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            resp_valid <= 1'b0;
            rdata      <= '0;
            drop_q     <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_present) begin
                        addr_q  <= v_addr[AW+1:0];
                        wr_q    <= (memory_rw == 2'b10);
                        size_q  <= number_length[1:0];
                        uns_q   <= number_length[2];
                        wdata_q <= wdata;
                        cnt     <= CW'(LATENCY - 1);
                        drop_q  <= 1'b0;
                    end
                end
                BUSY: begin
                    if (clear) drop_q <= 1'b1;
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        // A squashed read loses its response; a squashed store still reports
                        resp_valid <= wr_q | ~(drop_q | clear);
                        rdata      <= (wr_q || mis) ? 32'h0 : ext;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM1_ALIGN_CHECK_EN
    logic ale_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            ale_q <= 1'b0;
        end else if (do_access) begin
            ale_q <= mis;
        end
    end
    assign ale = ale_q;
`else
    assign ale = 1'b0;
`endif

endmodule

// File: tb/tb_mem1_data_responder.sv
// tb/tb_mem1_data_responder.sv - randomized model-checked bench for mem1_data_responder

module tb_mem1_data_responder;

    localparam int L     = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        clear;
    logic [31:0] v_addr;
    logic [1:0]  memory_rw;
    logic [2:0]  number_length;
    logic [31:0] wdata;
    logic        stall;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        ale;

    int checks = 0;
    int errors = 0;

    bit          chk_en = 1'b0;
    bit          exp_stall;
    bit          exp_resp;
    logic [31:0] exp_rdata;
    bit          exp_ale;

    logic [31:0] last_rdata;
    logic        last_ale;
    int          stall_cnt = 0;
    int          resp_cnt  = 0;

    logic [31:0] mm [DEPTH];

    always #5 clk = ~clk;

    mem1_data_responder #(.DEPTH(DEPTH), .LATENCY(L)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .clear(clear),
        .v_addr(v_addr),
        .memory_rw(memory_rw),
        .number_length(number_length),
        .wdata(wdata),
        .stall(stall),
        .resp_valid(resp_valid),
        .rdata(rdata),
        .ale(ale)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison against the expectations the driver publishes
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 32'(stall), 32'(exp_stall));
            chk("resp_valid", 32'(resp_valid), 32'(exp_resp));
            if (exp_resp) begin
                chk("rdata", rdata, exp_rdata);
                chk("ale", 32'(ale), 32'(exp_ale));
            end
            if (resp_valid) begin
                last_rdata = rdata;
                last_ale   = ale;
                resp_cnt++;
            end
            if (stall) stall_cnt++;
        end
    end

    // Byte-addressed reference: size in bytes, lane offset, mask/shift arithmetic
    task automatic model_access(input logic [1:0] rw, input logic [2:0] len, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] val, output bit al);
        int          nb;
        int          off;
        int          ix;
        logic [31:0] mask;
        logic [31:0] w;
        nb  = (len[1:0] == 2'b00) ? 1 : (len[1:0] == 2'b01) ? 2 : 4;
        off = int'(addr % 4);
        ix  = int'((addr / 4) % DEPTH);
        al  = 1'b0;
`ifdef MEM1_ALIGN_CHECK_EN
        if (off % nb != 0) al = 1'b1;
`else
        off = off - (off % nb);
`endif
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
        val  = 32'h0;
        if (!al) begin
            w = mm[ix];
            if (rw == 2'b10) begin
                mm[ix] = (w & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
            end else begin
                val = (w >> (8 * off)) & mask;
                if (!len[2] && nb < 4 && val[8*nb-1]) val = val | ~mask;
            end
        end
    endtask

    // One complete access; clr_k (1..L) pulses clear in that BUSY cycle, 0 = never
    task automatic access(input logic [1:0] rw, input logic [2:0] len, input logic [31:0] addr,
                          input logic [31:0] wd, input int clr_k);
        logic [31:0] val;
        bit          al;
        bit          is_rd;
        model_access(rw, len, addr, wd, val, al);
        is_rd = (rw == 2'b01);
        for (int k = 0; k <= L + 1; k++) begin
            @(posedge clk); #1;
            rst           = 1'b0;
            req_valid     = 1'b1;
            memory_rw     = rw;
            number_length = len;
            v_addr        = addr;
            wdata         = wd;
            clear         = (clr_k != 0) && (k == clr_k);
            exp_stall     = (k <= L);
            exp_resp      = (k == L + 1) && !(is_rd && clr_k != 0);
            exp_rdata     = is_rd ? val : 32'h0;
            exp_ale       = al;
        end
        @(negedge clk); #1;
    endtask

    task automatic idle_cycle(input logic rv, input logic [1:0] rw, input logic clr);
        @(posedge clk); #1;
        rst           = 1'b0;
        req_valid     = rv;
        memory_rw     = rw;
        clear         = clr;
        number_length = 3'($urandom_range(0, 7));
        v_addr        = $urandom;
        wdata         = $urandom;
        exp_stall     = 1'b0;
        exp_resp      = 1'b0;
        @(negedge clk); #1;
    endtask

    // Word store interrupted by rst in its first BUSY cycle; the model is left untouched
    task automatic store_with_reset(input logic [31:0] addr, input logic [31:0] wd);
        @(posedge clk); #1;
        req_valid = 1'b1; memory_rw = 2'b10; number_length = 3'b010;
        v_addr = addr; wdata = wd; clear = 1'b0; rst = 1'b0;
        exp_stall = 1'b1; exp_resp = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_stall = 1'b1; exp_resp = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        exp_stall = 1'b0; exp_resp = 1'b0;
        for (int k = 0; k < L + 2; k++) begin
            @(posedge clk); #1;
            exp_stall = 1'b0; exp_resp = 1'b0;
        end
        @(negedge clk); #1;
    endtask

    initial begin
        int rc;
        rst = 1'b1; req_valid = 1'b0; clear = 1'b0; v_addr = '0;
        memory_rw = 2'b00; number_length = 3'b000; wdata = '0;
        exp_stall = 1'b0; exp_resp = 1'b0; exp_rdata = '0; exp_ale = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset stall", 32'(stall), 32'h0);
        chk("reset resp_valid", 32'(resp_valid), 32'h0);
        chk("reset rdata", rdata, 32'h0);
        chk("reset ale", 32'(ale), 32'h0);
        rst = 1'b0;
        chk_en = 1'b1;

        access(2'b10, 3'b010, 32'h300, 32'h1122_3344, 0);

        stall_cnt = 0; rc = resp_cnt;
        access(2'b10, 3'b010, 32'h100, 32'hDEAD_BEEF, 0);
        chk("store stall cycles", 32'(stall_cnt), 32'd3);
        chk("store resp pulses", 32'(resp_cnt - rc), 32'd1);

        access(2'b01, 3'b010, 32'h100, 32'h0, 0);
        chk("word load 0x100", last_rdata, 32'hDEAD_BEEF);
        access(2'b01, 3'b000, 32'h103, 32'h0, 0);
        chk("signed byte 0x103", last_rdata, 32'hFFFF_FFDE);
        access(2'b01, 3'b100, 32'h103, 32'h0, 0);
        chk("unsigned byte 0x103", last_rdata, 32'h0000_00DE);

        access(2'b10, 3'b001, 32'h102, 32'h0000_1234, 0);
        access(2'b01, 3'b010, 32'h100, 32'h0, 0);
        chk("word after half store", last_rdata, 32'h1234_BEEF);
        access(2'b01, 3'b001, 32'h100, 32'h0, 0);
        chk("signed half 0x100", last_rdata, 32'hFFFF_BEEF);

        rc = resp_cnt;
        idle_cycle(1'b1, 2'b01, 1'b1);
        access(2'b01, 3'b010, 32'h100, 32'h0, 1);
        chk("squashed read no resp", 32'(resp_cnt - rc), 32'd0);
        access(2'b10, 3'b010, 32'h200, 32'hA5A5_0001, L);
        access(2'b01, 3'b010, 32'h200, 32'h0, 0);
        chk("store under clear", last_rdata, 32'hA5A5_0001);

        rc = resp_cnt;
        store_with_reset(32'h300, 32'h0000_0055);
        chk("reset store no resp", 32'(resp_cnt - rc), 32'd0);
        access(2'b01, 3'b010, 32'h300, 32'h0, 0);
        chk("aborted store", last_rdata, 32'h1122_3344);

        access(2'b01, 3'b010, 32'h1100, 32'h0, 0);
        chk("alias 0x1100", last_rdata, 32'h1234_BEEF);

        access(2'b10, 3'b010, 32'h102, 32'hCAFE_F00D, 0);
`ifdef MEM1_ALIGN_CHECK_EN
        chk("misaligned store ale", 32'(last_ale), 32'h1);
        access(2'b01, 3'b010, 32'h100, 32'h0, 0);
        chk("misaligned store blocked", last_rdata, 32'h1234_BEEF);
`else
        chk("forced-aligned store ale", 32'(last_ale), 32'h0);
        access(2'b01, 3'b010, 32'h100, 32'h0, 0);
        chk("forced-aligned store", last_rdata, 32'hCAFE_F00D);
`endif

        for (int i = 0; i < 16; i++) begin
            access(2'b10, 3'b010, 32'(i * 4), $urandom, 0);
        end

        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                case ($urandom_range(0, 2))
                    0:       idle_cycle(1'b0, 2'($urandom_range(0, 3)), 1'b0);
                    1:       idle_cycle(1'b1, ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00, 1'b0);
                    default: idle_cycle(1'b1, ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10, 1'b1);
                endcase
            end else begin
                access(($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10,
                       3'($urandom_range(0, 7)),
                       $urandom & 32'hFFFF_F03F,
                       $urandom,
                       ($urandom_range(0, 5) == 0) ? $urandom_range(1, L) : 0);
            end
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
